// File: rtl/quant_write_sched.sv
// quant_write_sched: round-robin burst scheduler feeding the shared quantization write pipeline.
module quant_write_sched #(
  parameter int SRAMC_W  = 1024,
  parameter int ADRC_W   = 12,
  parameter int SRAMC_N  = 32,
  parameter int N_REQ    = 2,
  parameter int PIPE_LAT = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*SRAMC_W-1:0]   i_req_wdata,
  input  logic [N_REQ*ADRC_W-1:0]    i_req_addr,
  input  logic [N_REQ*SRAMC_N-1:0]   i_req_wmask,
  input  logic [N_REQ-1:0]           i_req_last,
  input  logic                       i_stall,
  output logic [SRAMC_W-1:0]         o_sramc_wdata_q,
  output logic [ADRC_W-1:0]          o_sramc_addr_q,
  output logic                       o_sramc_wren_q,
  output logic [SRAMC_N-1:0]         o_sramc_wmask_q,
  output logic                       o_sramc_rden_q,
  output logic [N_REQ-1:0]           o_done,
  output logic                       o_busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, cand, grant, rr_nxt;
  logic has_cand, hs, last_sel;
  logic [SRAMC_W-1:0] wdata_d;
  logic [ADRC_W-1:0] addr_d;
  logic [SRAMC_N-1:0] wmask_d;
  logic wren_d;
  logic [PIPE_LAT:0] tv_q, tv_d, tl_q, tl_d;
  logic [PIPE_LAT:0][IW-1:0] tid_q, tid_d;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      owner_q         <= '0;
      rr_q            <= '0;
      o_sramc_wdata_q <= '0;
      o_sramc_addr_q  <= '0;
      o_sramc_wmask_q <= '0;
      o_sramc_wren_q  <= 1'b0;
      tv_q            <= '0;
      tl_q            <= '0;
      tid_q           <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_q            <= rr_d;
      o_sramc_wdata_q <= wdata_d;
      o_sramc_addr_q  <= addr_d;
      o_sramc_wmask_q <= wmask_d;
      o_sramc_wren_q  <= wren_d;
      tv_q            <= tv_d;
      tl_q            <= tl_d;
      tid_q           <= tid_d;
    end
  end
  // Scan downward so the requester closest above the rr pointer is assigned last and wins.
  always_comb begin
    int j;
    j = 0;
    cand = rr_q;
    has_cand = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      j = (j >= N_REQ) ? j - N_REQ : j;
      if (i_req_valid[j]) begin
        cand = IW'(j);
        has_cand = 1'b1;
      end
    end
  end
  always_comb begin
    grant = (state_q == BURST) ? owner_q : cand;
    o_req_ready = (((state_q == BURST) ? i_req_valid[owner_q] : has_cand) && !i_stall) ? (N_REQ'(1) << grant) : '0;
    hs = |o_req_ready;
    last_sel = i_req_last[grant];
    o_done = (tv_q[PIPE_LAT] && tl_q[PIPE_LAT]) ? (N_REQ'(1) << tid_q[PIPE_LAT]) : '0;
    o_busy = (state_q == BURST) || (|tv_q);
    o_sramc_rden_q = 1'b0;
  end
  always_comb begin
    rr_nxt = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
    state_d = !hs ? state_q : (last_sel ? IDLE : BURST);
    owner_d = hs ? grant : owner_q;
    rr_d = (hs && last_sel) ? rr_nxt : rr_q;
    wren_d = hs;
    wdata_d = hs ? i_req_wdata[int'(grant)*SRAMC_W +: SRAMC_W] : o_sramc_wdata_q;
    addr_d = hs ? i_req_addr[int'(grant)*ADRC_W +: ADRC_W] : o_sramc_addr_q;
    wmask_d = hs ? i_req_wmask[int'(grant)*SRAMC_N +: SRAMC_N] : o_sramc_wmask_q;
    tv_d = {tv_q[PIPE_LAT-1:0], hs};
    tl_d = {tl_q[PIPE_LAT-1:0], hs && last_sel};
    tid_d = {tid_q[PIPE_LAT-1:0], grant};
  end
endmodule

// File: tb/tb_quant_write_sched.sv
// tb_quant_write_sched: randomized scoreboard bench for the quantization write scheduler.
module tb_quant_write_sched;
  localparam int SW = 1024, AW = 12, MN = 32, NR = 2, PL = 6;
  typedef struct {
    logic [AW-1:0] a;
    logic [SW-1:0] d;
    logic [MN-1:0] m;
    logic          l;
  } beat_t;
  typedef struct {
    int    c;
    beat_t b;
  } iss_t;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic [NR-1:0] vld = '0, lst = '0, o_req_ready, o_done;
  logic [NR*SW-1:0] wdata = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*MN-1:0] wmask = '0;
  logic [SW-1:0] o_wdata;
  logic [AW-1:0] o_addr;
  logic [MN-1:0] o_wmask;
  logic o_wren, o_rden, o_busy;
  int total = 0, bad = 0, cyc = 0;
  beat_t rq [NR][$];
  iss_t ex_q [$];
  logic [NR-1:0] exp_done [int];
  bit exp_burst [int];
  int own = -1, rr = 0, last_acc = -100;
  quant_write_sched #(.SRAMC_W(SW), .ADRC_W(AW), .SRAMC_N(MN), .N_REQ(NR), .PIPE_LAT(PL)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(vld), .o_req_ready(o_req_ready),
    .i_req_wdata(wdata), .i_req_addr(addr), .i_req_wmask(wmask), .i_req_last(lst),
    .i_stall(stall), .o_sramc_wdata_q(o_wdata), .o_sramc_addr_q(o_addr),
    .o_sramc_wren_q(o_wren), .o_sramc_wmask_q(o_wmask), .o_sramc_rden_q(o_rden),
    .o_done(o_done), .o_busy(o_busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, e);
    end
  endtask
  task automatic push_burst(input int k, input int n, input logic [AW-1:0] base, input bit full);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < SW / 32; w++) b.d[w*32 +: 32] = $urandom();
      b.a = base + AW'(i);
      b.m = full ? '1 : MN'($urandom());
      b.l = (i == n - 1);
      rq[k].push_back(b);
    end
  endtask
  // Reference: burst-atomic round robin expressed directly on requester numbers.
  task automatic tick(input logic [NR-1:0] gate, input logic st);
    int acc, idx;
    beat_t b;
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      vld[k] = (rq[k].size() > 0) && gate[k];
      if (rq[k].size() > 0) begin
        b = rq[k][0];
        wdata[k*SW +: SW] = b.d;
        addr[k*AW +: AW] = b.a;
        wmask[k*MN +: MN] = b.m;
        lst[k] = b.l;
      end else lst[k] = 1'b0;
    end
    stall = st;
    acc = -1;
    if (!st) begin
      if (own >= 0) begin
        if (vld[own]) acc = own;
      end else
        for (int i = 0; i < NR; i++) begin
          idx = (rr + i) % NR;
          if (acc < 0 && vld[idx]) acc = idx;
        end
    end
    #1 chk("ready", 64'(o_req_ready), (acc >= 0) ? 64'(1) << acc : 64'(0));
    if (acc >= 0) begin
      b = rq[acc].pop_front();
      ex_q.push_back('{cyc + 1, b});
      if (b.l) begin
        exp_done[cyc+1+PL] = (exp_done.exists(cyc+1+PL) ? exp_done[cyc+1+PL] : '0) | (NR'(1) << acc);
        own = -1;
        rr = (acc + 1) % NR;
      end else own = acc;
      last_acc = cyc;
    end
    exp_burst[cyc+1] = (own >= 0);
  endtask
  initial begin : monitor
    iss_t it;
    bit ew, eb;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        ew = (ex_q.size() > 0) && (ex_q[0].c == cyc);
        chk("wren", 64'(o_wren), 64'(ew));
        if (ew) begin
          it = ex_q.pop_front();
          chk("addr", 64'(o_addr), 64'(it.b.a));
          chk("wmask", 64'(o_wmask), 64'(it.b.m));
          chk("wdata_match", 64'(o_wdata == it.b.d), 64'(1));
        end
        chk("done", 64'(o_done), exp_done.exists(cyc) ? 64'(exp_done[cyc]) : 64'(0));
        eb = (exp_burst.exists(cyc) && exp_burst[cyc]) || (cyc - last_acc >= 1 && cyc - last_acc <= PL + 1);
        chk("busy", 64'(o_busy), 64'(eb));
        chk("rden", 64'(o_rden), 64'(0));
      end
    end
  end
  initial begin : stim
    int n;
    repeat (2) @(negedge clk);
    chk("rst_wren", 64'(o_wren), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("rst_addr", 64'(o_addr), 0);
    rst = 1'b0;
    push_burst(0, 3, 12'h010, 1'b1);
    repeat (PL + 6) tick(2'b11, 1'b0);
    push_burst(0, 2, 12'h100, 1'b0);
    push_burst(1, 2, 12'h200, 1'b0);
    repeat (PL + 6) tick(2'b11, 1'b0);
    for (int i = 0; i < 3; i++) push_burst(1, 1, 12'h300 + AW'(i), 1'b0);
    repeat (PL + 5) tick(2'b11, 1'b0);
    push_burst(0, 4, 12'h400, 1'b0);
    push_burst(1, 2, 12'h500, 1'b0);
    tick(2'b11, 1'b0);
    repeat (4) tick(2'b11, 1'b1);
    tick(2'b11, 1'b0);
    repeat (2) tick(2'b10, 1'b0);
    repeat (PL + 8) tick(2'b11, 1'b0);
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NR; k++)
        if (rq[k].size() == 0 && $urandom_range(3) == 0)
          push_burst(k, $urandom_range(1, 4), AW'($urandom()), 1'b0);
      tick(NR'($urandom()) | NR'($urandom()) | NR'($urandom()), $urandom_range(6) == 0);
    end
    n = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0) && n < 200) begin
      tick(2'b11, 1'b0);
      n++;
    end
    chk("drain_in_budget", 64'(n < 200), 1);
    repeat (PL + 3) tick(2'b11, 1'b0);
    chk("scoreboard_empty", 64'(ex_q.size()), 0);
    push_burst(0, 1, 12'h7A0, 1'b0);
    repeat (4) tick(2'b11, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 64'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_wren", 64'(o_wren), 0);
    chk("arst_addr", 64'(o_addr), 0);
    chk("arst_busy", 64'(o_busy), 0);
    chk("arst_done", 64'(o_done), 0);
    ex_q.delete();
    exp_done.delete();
    exp_burst.delete();
    own = -1;
    rr = 0;
    last_acc = -100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_burst(0, 1, 12'h7B0, 1'b0);
    push_burst(1, 1, 12'h7C0, 1'b0);
    repeat (PL + 6) tick(2'b11, 1'b0);
    chk("final_empty", 64'(ex_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
